// File: rtl/vstore_deshuffle.sv
// Vector store deshuffle stage.
// Gathers one DLEN-wide entry from every lane, restores sequential element
// order and attaches nibble enables that cover vstart, the vl tail and the
// per-byte lane enables. One sequential entry leaves per beat over a
// valid/ready handshake; done_o marks command completion.
module vstore_deshuffle #(
   parameter int unsigned NrExits = 4,
   parameter int unsigned DLEN    = 64,
   parameter int unsigned VlWidth = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   // command
   input  logic                        cmd_valid_i,
   output logic                        cmd_ready_o,
   input  logic [1:0]                  cmd_sew_i,
   input  logic [VlWidth-1:0]          cmd_vl_i,
   input  logic [VlWidth-1:0]          cmd_vstart_i,
   // lane entries
   input  logic [NrExits-1:0]          lane_valid_i,
   output logic [NrExits-1:0]          lane_ready_o,
   input  logic [NrExits*DLEN-1:0]     lane_data_i,
   input  logic [NrExits*DLEN/8-1:0]   lane_be_i,
   // sequential output
   output logic                        tx_valid_o,
   input  logic                        tx_ready_i,
   output logic [NrExits*DLEN-1:0]     tx_nb_o,
   output logic [NrExits*DLEN/4-1:0]   tx_en_o,
   output logic                        tx_last_o,
   output logic                        done_o
);

   localparam int unsigned EntryBytes = NrExits * DLEN / 8;
   localparam int unsigned EntryNbs   = 2 * EntryBytes;
   localparam int unsigned LaneBytes  = DLEN / 8;
   localparam int unsigned EbLog      = $clog2(EntryBytes);
   // One extra bit so element indices never wrap at vl = 2^VlWidth-1.
   localparam int unsigned ElW        = VlWidth + 1;

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } state_e;

   state_e                      state_q;
   logic [1:0]                  sew_q;
   logic [ElW-1:0]              vl_q;
   logic [ElW-1:0]              vstart_q;
   logic [ElW-1:0]              base_q;
   logic [ElW-1:0]              moved_q;
   logic [ElW-1:0]              total_q;
   logic                        done_pend_q;

   logic [NrExits-1:0]          stg_full_q;
   logic [NrExits*DLEN-1:0]     stg_data_q;
   logic [NrExits*DLEN/8-1:0]   stg_be_q;

   // ------------------------------------------------------------------
   // Command decode: entry span of the command in sequential entries.
   // ------------------------------------------------------------------
   logic [ElW-1:0] cmd_vl_x;
   logic [ElW-1:0] cmd_vstart_x;
   logic [7:0]     cmd_shift;
   logic [ElW-1:0] cmd_epe;
   logic [ElW-1:0] cmd_first;
   logic [ElW-1:0] cmd_last;
   logic [ElW-1:0] cmd_base;
   logic [ElW-1:0] cmd_total;
   logic           cmd_empty;
   logic           cmd_hs;

   assign cmd_vl_x     = ElW'(cmd_vl_i);
   assign cmd_vstart_x = ElW'(cmd_vstart_i);
   // Elements per entry is a power of two, so divisions become shifts.
   assign cmd_shift    = 8'(EbLog) - 8'(cmd_sew_i);
   assign cmd_epe      = ElW'(EntryBytes) >> cmd_sew_i;
   assign cmd_first    = cmd_vstart_x >> cmd_shift;
   assign cmd_last     = (cmd_vl_x + cmd_epe - ElW'(1)) >> cmd_shift;
   assign cmd_base     = cmd_first << cmd_shift;
   assign cmd_empty    = (cmd_vstart_x >= cmd_vl_x);
   assign cmd_total    = cmd_empty ? '0 : (cmd_last - cmd_first);

   assign cmd_ready_o  = (state_q == S_IDLE);
   assign cmd_hs       = cmd_valid_i && cmd_ready_o;

   // ------------------------------------------------------------------
   // Lane acceptance and the move condition.
   // ------------------------------------------------------------------
   logic                active;
   logic                can_take;
   logic                out_free;
   logic                more_after;
   logic [NrExits-1:0]  eff_full;
   logic                move;
   logic [NrExits-1:0]  lane_hs;
   logic [ElW-1:0]      epe_q;

   assign active     = (state_q == S_ACTIVE);
   assign can_take   = active && (moved_q < total_q);
   assign out_free   = !tx_valid_o || tx_ready_i;
   assign more_after = (moved_q + ElW'(1)) < total_q;
   assign epe_q      = ElW'(EntryBytes) >> sew_q;

   // A lane arriving this cycle counts as present, so a beat can leave one
   // cycle after the last lane's handshake instead of waiting in staging.
   assign eff_full   = stg_full_q | (lane_valid_i & {NrExits{can_take}});
   assign move       = (&eff_full) && out_free;

   assign lane_ready_o = {NrExits{active}} &
                         ((~stg_full_q & {NrExits{moved_q < total_q}}) |
                          {NrExits{move && more_after}});
   assign lane_hs      = lane_valid_i & lane_ready_o;

   // ------------------------------------------------------------------
   // Per-lane source for the beat being moved: staged entry or bypass.
   // ------------------------------------------------------------------
   logic [NrExits*DLEN-1:0]   cur_data;
   logic [NrExits*DLEN/8-1:0] cur_be;

   // Select staged or incoming lane entry for every lane.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      cur_data = stg_data_q;
      cur_be   = stg_be_q;
      for (int l = 0; l < NrExits; l++) begin
         if (!stg_full_q[l]) begin
            cur_data[l*DLEN +: DLEN]           = lane_data_i[l*DLEN +: DLEN];
            cur_be[l*LaneBytes +: LaneBytes]   = lane_be_i[l*LaneBytes +: LaneBytes];
         end
      end
   end

   // ------------------------------------------------------------------
   // Element window: element e of the current beat is active when
   // vstart <= base+e < vl.
   // ------------------------------------------------------------------
   logic [EntryBytes-1:0] elem_on;

   for (genvar e = 0; e < EntryBytes; e++) begin : g_elem
      logic [ElW-1:0] idx;
      assign idx        = base_q + ElW'(e);
      assign elem_on[e] = (idx >= vstart_q) && (idx < vl_q);
   end

   // ------------------------------------------------------------------
   // Deshuffle: static byte routing for each element width, selected by sew.
   // Element e lives in lane e mod NrExits at slot e / NrExits.
   // ------------------------------------------------------------------
   logic [3:0][NrExits*DLEN-1:0] map_nb;
   logic [3:0][EntryNbs-1:0]     map_en;

   for (genvar s = 0; s < 4; s++) begin : g_sew
      for (genvar b = 0; b < EntryBytes; b++) begin : g_byte
         localparam int unsigned Elem = b >> s;
         localparam int unsigned Kb   = b % (1 << s);
         localparam int unsigned Ln   = Elem % NrExits;
         localparam int unsigned Lb   = ((Elem / NrExits) << s) + Kb;
         localparam int unsigned Src  = Ln * LaneBytes + Lb;
         assign map_nb[s][b*8 +: 8] = cur_data[Src*8 +: 8];
         assign map_en[s][b*2 +: 2] = {2{cur_be[Src] && elem_on[Elem]}};
      end
   end

   logic [NrExits*DLEN-1:0] desh_nb;
   logic [EntryNbs-1:0]     desh_en;

   assign desh_nb = map_nb[sew_q];
   assign desh_en = map_en[sew_q];

   // ------------------------------------------------------------------
   // Control FSM with command bookkeeping.
   // ------------------------------------------------------------------
   // Track command phase, beat base and beat counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         sew_q       <= '0;
         vl_q        <= '0;
         vstart_q    <= '0;
         base_q      <= '0;
         moved_q     <= '0;
         total_q     <= '0;
         done_pend_q <= 1'b0;
      end else begin
         done_pend_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_hs) begin
                  sew_q    <= cmd_sew_i;
                  vl_q     <= cmd_vl_x;
                  vstart_q <= cmd_vstart_x;
                  base_q   <= cmd_base;
                  total_q  <= cmd_total;
                  moved_q  <= '0;
                  if (cmd_empty) begin
                     done_pend_q <= 1'b1;
                  end else begin
                     state_q <= S_ACTIVE;
                  end
               end
            end
            S_ACTIVE: begin
               if (move) begin
                  base_q  <= base_q + epe_q;
                  moved_q <= moved_q + ElW'(1);
               end
               if (tx_valid_o && tx_ready_i && tx_last_o) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Staging registers.
   // ------------------------------------------------------------------
   // Staging occupancy: cleared by move, set by a lane handshake that is
   // not bypassed straight into the output register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stg_full_q <= '0;
      end else if (move) begin
         stg_full_q <= lane_hs & stg_full_q;
      end else begin
         stg_full_q <= stg_full_q | lane_hs;
      end
   end

   // Staging payload capture on each lane handshake.
   // NOTE: payload storage has no reset; the full flags alone decide
   // whether its contents are ever used.
   always_ff @(posedge clk_i) begin
      for (int l = 0; l < NrExits; l++) begin
         if (lane_hs[l]) begin
            stg_data_q[l*DLEN +: DLEN]         <= lane_data_i[l*DLEN +: DLEN];
            stg_be_q[l*LaneBytes +: LaneBytes] <= lane_be_i[l*LaneBytes +: LaneBytes];
         end
      end
   end

   // ------------------------------------------------------------------
   // Output register, one entry deep.
   // ------------------------------------------------------------------
   // Load on move, hold under backpressure, drain on handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_valid_o <= 1'b0;
         tx_last_o  <= 1'b0;
         tx_nb_o    <= '0;
         tx_en_o    <= '0;
      end else if (move) begin
         tx_valid_o <= 1'b1;
         tx_last_o  <= (moved_q + ElW'(1)) == total_q;
         tx_nb_o    <= desh_nb;
         tx_en_o    <= desh_en;
      end else if (tx_ready_i) begin
         tx_valid_o <= 1'b0;
         tx_last_o  <= 1'b0;
      end
   end

   // Completion: empty commands pulse one cycle after acceptance, others on
   // the handshake of their last beat.
   assign done_o = done_pend_q || (tx_valid_o && tx_ready_i && tx_last_o);

endmodule

// File: tb/tb_vstore_deshuffle.sv
// Self-checking bench for vstore_deshuffle: scenario tasks drive lanes and
// the command port; a queue scoreboard holds the expected sequential beats.
module tb_vstore_deshuffle;

   localparam int NrExits    = 4;
   localparam int DLEN       = 64;
   localparam int VlWidth    = 16;
   localparam int EntryBytes = NrExits * DLEN / 8;
   localparam int EntryNbs   = 2 * EntryBytes;
   localparam int LaneBytes  = DLEN / 8;
   localparam int MaxBeats   = 32;

   logic                        clk_i = 1'b0;
   logic                        rst_ni;
   logic                        cmd_valid_i;
   logic                        cmd_ready_o;
   logic [1:0]                  cmd_sew_i;
   logic [VlWidth-1:0]          cmd_vl_i;
   logic [VlWidth-1:0]          cmd_vstart_i;
   logic [NrExits-1:0]          lane_valid_i;
   logic [NrExits-1:0]          lane_ready_o;
   logic [NrExits*DLEN-1:0]     lane_data_i;
   logic [NrExits*DLEN/8-1:0]   lane_be_i;
   logic                        tx_valid_o;
   logic                        tx_ready_i;
   logic [NrExits*DLEN-1:0]     tx_nb_o;
   logic [EntryNbs-1:0]         tx_en_o;
   logic                        tx_last_o;
   logic                        done_o;

   vstore_deshuffle #(
      .NrExits (NrExits),
      .DLEN    (DLEN),
      .VlWidth (VlWidth)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_sew_i    (cmd_sew_i),
      .cmd_vl_i     (cmd_vl_i),
      .cmd_vstart_i (cmd_vstart_i),
      .lane_valid_i (lane_valid_i),
      .lane_ready_o (lane_ready_o),
      .lane_data_i  (lane_data_i),
      .lane_be_i    (lane_be_i),
      .tx_valid_o   (tx_valid_o),
      .tx_ready_i   (tx_ready_i),
      .tx_nb_o      (tx_nb_o),
      .tx_en_o      (tx_en_o),
      .tx_last_o    (tx_last_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [NrExits*DLEN-1:0] nb;
      logic [EntryNbs-1:0]     en;
      logic                    last;
   } beat_t;

   beat_t exp_q[$];
   int    checks   = 0;
   int    failures = 0;

   logic [DLEN-1:0]      mem_d  [NrExits][MaxBeats];
   logic [LaneBytes-1:0] mem_be [NrExits][MaxBeats];

   int lane_start [NrExits];
   int stall_from;
   int stall_len;
   int first_valid_cyc;
   int bubbles;
   int late_ready;
   int idx_stall_end [NrExits];

   task automatic idle_inputs();
      cmd_valid_i  = 1'b0;
      cmd_sew_i    = '0;
      cmd_vl_i     = '0;
      cmd_vstart_i = '0;
      lane_valid_i = '0;
      lane_data_i  = '0;
      lane_be_i    = '0;
      tx_ready_i   = 1'b0;
   endtask

   task automatic fill_random(input bit all_be);
      for (int l = 0; l < NrExits; l++) begin
         for (int i = 0; i < MaxBeats; i++) begin
            mem_d[l][i]  = {$urandom(), $urandom()};
            mem_be[l][i] = all_be ? '1 : LaneBytes'($urandom());
         end
      end
   endtask

   // Reference: walk the sequential elements of each beat and fetch their
   // bytes from the lane that owns them.
   task automatic model_push(input int sew, input int vl, input int vstart);
      int    esz, epe, first, total, g, lane, slot;
      beat_t bt;
      esz   = 1 << sew;
      epe   = EntryBytes / esz;
      first = vstart / epe;
      total = (vstart >= vl) ? 0 : ((vl + epe - 1) / epe) - first;
      for (int i = 0; i < total; i++) begin
         bt.nb   = '0;
         bt.en   = '0;
         bt.last = (i == total - 1);
         for (int e = 0; e < epe; e++) begin
            g    = (first + i) * epe + e;
            lane = e % NrExits;
            slot = e / NrExits;
            for (int k = 0; k < esz; k++) begin
               bt.nb[(e*esz + k)*8 +: 8] = mem_d[lane][i][(slot*esz + k)*8 +: 8];
               bt.en[(e*esz + k)*2 +: 2] =
                  {2{mem_be[lane][i][slot*esz + k] && (g >= vstart) && (g < vl)}};
            end
         end
         exp_q.push_back(bt);
      end
   endtask

   task automatic issue_cmd(input int sew, input int vl, input int vstart);
      cmd_valid_i  = 1'b1;
      cmd_sew_i    = 2'(sew);
      cmd_vl_i     = VlWidth'(vl);
      cmd_vstart_i = VlWidth'(vstart);
      @(negedge clk_i);
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL cmd_ready: got %b want 1", cmd_ready_o);
      end
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
   endtask

   // Cycle-driven lane/tx driver. Compares every tx handshake against the
   // scoreboard and checks that a stalled beat is held unchanged.
   task automatic stream(input int n_beats, input int max_cyc);
      int                      idx [NrExits];
      int                      got;
      int                      cyc;
      logic                    prev_stall;
      logic [NrExits*DLEN-1:0] prev_nb;
      logic [EntryNbs-1:0]     prev_en;
      beat_t                   ex;
      for (int l = 0; l < NrExits; l++) begin
         idx[l]           = 0;
         idx_stall_end[l] = 0;
      end
      got             = 0;
      cyc             = 0;
      prev_stall      = 1'b0;
      prev_nb         = '0;
      prev_en         = '0;
      first_valid_cyc = -1;
      bubbles         = 0;
      late_ready      = 0;
      while (got < n_beats && cyc < max_cyc) begin
         for (int l = 0; l < NrExits; l++) begin
            if (idx[l] < n_beats && cyc >= lane_start[l]) begin
               lane_valid_i[l]                       = 1'b1;
               lane_data_i[l*DLEN +: DLEN]           = mem_d[l][idx[l]];
               lane_be_i[l*LaneBytes +: LaneBytes]   = mem_be[l][idx[l]];
            end else begin
               lane_valid_i[l] = 1'b0;
            end
         end
         tx_ready_i = !(cyc >= stall_from && cyc < stall_from + stall_len);
         @(negedge clk_i);
         if (prev_stall) begin
            checks++;
            if (tx_valid_o !== 1'b1 || tx_nb_o !== prev_nb || tx_en_o !== prev_en) begin
               failures++;
               $display("FAIL hold cyc=%0d: valid=%b nb=%h en=%h want nb=%h en=%h",
                        cyc, tx_valid_o, tx_nb_o, tx_en_o, prev_nb, prev_en);
            end
         end
         if (tx_valid_o === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (first_valid_cyc >= 0 && tx_valid_o !== 1'b1) bubbles++;
         if (!tx_ready_i && cyc > stall_from && lane_ready_o !== '0) late_ready++;
         for (int l = 0; l < NrExits; l++) begin
            if (lane_valid_i[l] && lane_ready_o[l] === 1'b1) idx[l]++;
         end
         if (cyc == stall_from + stall_len - 1) begin
            for (int l = 0; l < NrExits; l++) idx_stall_end[l] = idx[l];
         end
         if (tx_valid_o === 1'b1 && tx_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat cyc=%0d: nb=%h", cyc, tx_nb_o);
            end else begin
               ex = exp_q.pop_front();
               if (tx_nb_o !== ex.nb) begin
                  failures++;
                  $display("FAIL beat%0d_nb: got %h want %h", got, tx_nb_o, ex.nb);
               end
               checks++;
               if (tx_en_o !== ex.en) begin
                  failures++;
                  $display("FAIL beat%0d_en: got %h want %h", got, tx_en_o, ex.en);
               end
               checks++;
               if (tx_last_o !== ex.last) begin
                  failures++;
                  $display("FAIL beat%0d_last: got %b want %b", got, tx_last_o, ex.last);
               end
               checks++;
               if (done_o !== ex.last) begin
                  failures++;
                  $display("FAIL beat%0d_done: got %b want %b", got, done_o, ex.last);
               end
            end
            got++;
         end
         prev_stall = (tx_valid_o === 1'b1) && !tx_ready_i;
         prev_nb    = tx_nb_o;
         prev_en    = tx_en_o;
         @(posedge clk_i);
         #1;
         cyc++;
      end
      checks++;
      if (got < n_beats) begin
         failures++;
         $display("FAIL stream_timeout: got %0d beats want %0d", got, n_beats);
      end
      lane_valid_i = '0;
      tx_ready_i   = 1'b0;
   endtask

   task automatic check_queue_empty(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_leftover: %0d beats pending want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_quiet(input string name);
      checks++;
      if (tx_valid_o !== 1'b0 || lane_ready_o !== '0 || cmd_ready_o !== 1'b1 ||
          done_o !== 1'b0 || tx_last_o !== 1'b0) begin
         failures++;
         $display("FAIL %s: valid=%b lane_ready=%b cmd_ready=%b done=%b last=%b want 0,0,1,0,0",
                  name, tx_valid_o, lane_ready_o, cmd_ready_o, done_o, tx_last_o);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_ni = 1'b0;
      #12;
      check_quiet("reset_state");
      checks++;
      if (tx_nb_o !== '0 || tx_en_o !== '0) begin
         failures++;
         $display("FAIL reset_data: nb=%h en=%h want 0", tx_nb_o, tx_en_o);
      end
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      // Start a command, load a beat, then reset with it pending.
      fill_random(1'b1);
      issue_cmd(2, 16, 0);
      lane_valid_i = '1;
      lane_be_i    = '1;
      tx_ready_i   = 1'b0;
      @(posedge clk_i);
      #1;
      lane_valid_i = '0;
      @(negedge clk_i);
      checks++;
      if (tx_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL midcmd_loaded: valid=%b want 1", tx_valid_o);
      end
      rst_ni = 1'b0;
      #1;
      check_quiet("reset_async");
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      for (int c = 0; c < 3; c++) begin
         lane_valid_i = '1;
         @(negedge clk_i);
         check_quiet("reset_release");
         @(posedge clk_i);
         #1;
      end
      idle_inputs();
   endtask

   task automatic test_basic_order();
      beat_t bt;
      for (int l = 0; l < NrExits; l++) begin
         mem_d[l][0]  = {16'(l), 16'(1), 16'(l), 16'(0)};
         mem_be[l][0] = '1;
      end
      bt.last = 1'b1;
      bt.en   = '1;
      for (int e = 0; e < 8; e++) bt.nb[e*32 +: 32] = {16'(e % 4), 16'(e / 4)};
      exp_q.push_back(bt);
      lane_start = '{0, 0, 0, 0};
      stall_from = 1000;
      stall_len  = 0;
      issue_cmd(2, 8, 0);
      stream(1, 50);
      check_queue_empty("basic");
   endtask

   task automatic test_prestart_tail();
      beat_t b0, b1;
      fill_random(1'b1);
      model_push(0, 40, 3);
      b1 = exp_q.pop_back();
      b0 = exp_q.pop_back();
      b0.en = {{(EntryNbs-6){1'b1}}, 6'b0};
      b1.en = {{(EntryNbs-16){1'b0}}, 16'hFFFF};
      exp_q.push_back(b0);
      exp_q.push_back(b1);
      lane_start = '{0, 0, 0, 0};
      stall_from = 1000;
      stall_len  = 0;
      issue_cmd(0, 40, 3);
      stream(2, 50);
      check_queue_empty("prestart");
   endtask

   task automatic test_skew_backpressure();
      fill_random(1'b0);
      model_push(2, 24, 0);
      lane_start = '{0, 3, 1, 5};
      stall_from = 6;
      stall_len  = 4;
      issue_cmd(2, 24, 0);
      stream(3, 100);
      checks++;
      if (first_valid_cyc != 6) begin
         failures++;
         $display("FAIL skew_latency: first tx_valid cycle %0d want 6", first_valid_cyc);
      end
      checks++;
      if (late_ready != 0) begin
         failures++;
         $display("FAIL skew_ready_block: %0d stalled cycles with lane_ready set want 0", late_ready);
      end
      for (int l = 0; l < NrExits; l++) begin
         checks++;
         if (idx_stall_end[l] != 2) begin
            failures++;
            $display("FAIL skew_accept_lane%0d: %0d entries taken by stall end want 2",
                     l, idx_stall_end[l]);
         end
      end
      check_queue_empty("skew");
   endtask

   task automatic test_empty_cmd();
      issue_cmd(0, 10, 10);
      lane_valid_i = '1;
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b1 || lane_ready_o !== '0 || tx_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL empty_done: done=%b lane_ready=%b valid=%b want 1,0,0",
                  done_o, lane_ready_o, tx_valid_o);
      end
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check_quiet("empty_after");
      @(posedge clk_i);
      #1;
      lane_valid_i = '0;
   endtask

   task automatic test_vl_max();
      fill_random(1'b0);
      model_push(3, 65535, 65528);
      lane_start = '{0, 0, 0, 0};
      stall_from = 1000;
      stall_len  = 0;
      issue_cmd(3, 65535, 65528);
      stream(2, 50);
      check_queue_empty("vlmax");
   endtask

   task automatic test_streaming();
      fill_random(1'b0);
      model_push(3, 64, 0);
      lane_start = '{0, 0, 0, 0};
      stall_from = 1000;
      stall_len  = 0;
      issue_cmd(3, 64, 0);
      stream(16, 200);
      checks++;
      if (bubbles != 0) begin
         failures++;
         $display("FAIL stream_bubbles: %0d idle cycles want 0", bubbles);
      end
      for (int c = 0; c < 2; c++) begin
         lane_valid_i = '1;
         @(negedge clk_i);
         checks++;
         if (lane_ready_o !== '0) begin
            failures++;
            $display("FAIL stream_ready_after: lane_ready=%b want 0", lane_ready_o);
         end
         @(posedge clk_i);
         #1;
      end
      lane_valid_i = '0;
      check_queue_empty("stream");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_order();
      test_prestart_tail();
      test_skew_backpressure();
      test_empty_cmd();
      test_vl_max();
      test_streaming();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vstore_deshuffle.md
Name: vstore_deshuffle

Overview:
- Sits directly upstream of the vector sequential store stage.
- Collects one DLEN-wide store-data entry from each of NrExits lanes and undoes the lane interleaving into sequential element order.
- Generates nibble enables covering vstart, the tail (vl) and the per-byte lane enables.
- Emits one sequential-buffer entry per beat (nibbles plus nibble enables) over a valid/ready handshake.

Parameters:
- NrExits, 4, number of lanes feeding the block.
- DLEN, 64, bits per lane entry (power of two, ≥64).
- VlWidth, 16, width of vl/vstart fields.
- Derived, not overridable: EntryBytes = NrExits*DLEN/8; EntryNbs = 2*EntryBytes.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- cmd_valid_i  in  1  store command valid.
- cmd_ready_o  out  1  command accepted.
- cmd_sew_i  in  2  0=8b, 1=16b, 2=32b, 3=64b.
- cmd_vl_i  in  VlWidth  vector length in elements.
- cmd_vstart_i  in  VlWidth  first active element.
- lane_valid_i  in  NrExits  per-lane entry valid.
- lane_ready_o  out  NrExits  per-lane entry accepted.
- lane_data_i  in  NrExits*DLEN  lane l occupies bits [l*DLEN +: DLEN].
- lane_be_i  in  NrExits*DLEN/8  per-lane byte enables (mask result).
- tx_valid_o  out  1  sequential entry valid.
- tx_ready_i  in  1  downstream accepts entry.
- tx_nb_o  out  4*EntryNbs  nibbles in sequential order.
- tx_en_o  out  EntryNbs  nibble enables.
- tx_last_o  out  1  final entry of command.
- done_o  out  1  one-cycle pulse when the command completes.

Behaviour:
- Clocking/reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: state=S_IDLE, all staging flags empty, output register empty, counters 0. Outputs: cmd_ready_o=1, lane_ready_o=0, tx_valid_o=0, tx_last_o=0, done_o=0, tx_nb_o=0, tx_en_o=0.
- Reset mid-command discards all staged and output data; no done_o is produced.
- FSM states: S_IDLE, S_ACTIVE.
  - S_IDLE: cmd_ready_o=1. On cmd handshake, latch sew, vl and vstart.
  - Per-command values: EPE = EntryBytes>>sew; base_r = floor(vstart/EPE)*EPE; total = ceil(vl/EPE) − floor(vstart/EPE); moved_r = 0.
  - If vstart ≥ vl, total=0: stay in S_IDLE and pulse done_o on the next cycle.
  - Otherwise go to S_ACTIVE. Accepting the next command in S_IDLE while this done_o pulse is pending is legal.
- Staging: one register per lane (data, be, full flag).
  - move = &stg_full && (!tx_valid_o || tx_ready_i).
  - lane_ready_o[l] = S_ACTIVE && ((!stg_full[l] && moved_r < total) || (move && moved_r+1 < total)).
  - A lane never accepts more than total entries.
  - Staging is cleared by move, and can be refilled in the same cycle.
- Deshuffle (combinational, on move):
  - For sequential byte b: element e = b>>sew, k = b mod (1<<sew), lane = e mod NrExits, lane byte = ((e/NrExits)<<sew)+k.
  - Both nibbles of byte b take that lane byte's data and be.
  - en is additionally cleared when (base_r+e) < vstart or (base_r+e) ≥ vl.
- Output register, one entry deep.
  - Loaded on move. On load: base_r += EPE, moved_r += 1, tx_last set when moved_r+1 == total.
  - Held stable while tx_valid_o && !tx_ready_i.
- Latency: the last lane's handshake in cycle N gives tx_valid_o in cycle N+1.
- Throughput: one entry per cycle when all lanes stream and tx_ready_i=1.
- Completion: the handshake on the tx_last_o beat pulses done_o in the same cycle and returns the FSM to S_IDLE.
- Lane valids arriving in S_IDLE are ignored (ready=0).
- Arithmetic: base_r and element comparisons are VlWidth+1 bits wide, so no wrap at vl = 2^VlWidth−1.

Test Plan:
- Reset release: rst_ni low mid-command, then release → tx_valid_o=0, lane_ready_o=0, cmd_ready_o=1, no done_o.
- Basic ordering: NrExits=4, DLEN=64, sew=2, vl=8, vstart=0; lane l word j = {l,j}; all be=1 → one beat, tx_last_o=1, element order L0W0,L1W0,L2W0,L3W0,L0W1,…, tx_en_o all ones, done_o on the handshake.
- Prestart and tail masking: sew=0, vl=40, vstart=3 → 2 beats. Beat0 nibbles 0–5 en=0, rest 1. Beat1 en=1 for nibbles 0–15 only; tx_last_o on beat1.
- Skewed lanes with backpressure: lanes arrive in cycles 0, 3, 1, 5 → tx_valid_o at cycle 6. tx_ready_i low for 4 cycles → tx_nb_o/tx_en_o stable, early lanes for the next beat accepted once, then ready=0.
- Empty command: vstart=10, vl=10 → zero beats, done_o one cycle after the cmd handshake, lane_ready_o stays 0.
- Streaming: sew=3, vl=64 (16 beats), all lanes always valid, tx_ready_i=1 → 16 consecutive tx beats, no bubbles, lane_ready_o deasserts after the 16th entry.
